interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
//  8051-style five-source, two-level interrupt controller that sequences the control unit into ISRs.
//  Latches external/timer/serial requests, and arbitrates by IP level then fixed polling order.
//  At an instruction boundary it presents a vector and holds it until the control unit acks the LCALL-style stack push/jump.
//  Tracks in-service levels for nesting and releases them on RETI.
// PARAMETERS
//  ADDR_W      16      width of vector_addr
//  VEC_BASE    16'h0003 vector of source 0 (IE0)
//  VEC_STRIDE  16'h0008 spacing between successive source vectors
// PORTS
//  clock          in   1       system clock, rising edge
//  reset_n        in   1       asynchronous, active-low reset
//  ext_int_n      in   2       external pins INT0/INT1, active-low, asynchronous
//  it_mode        in   2       1 = edge-triggered (falling edge), 0 = level, per INTx
//  tf_set         in   2       1-cycle timer0/timer1 overflow pulses
//  serial_irq     in   1       RI|TI level from serial port (never cleared here)
//  ie_reg         in   8       IE: [7]=EA [4]=ES [3]=ET1 [2]=EX1 [1]=ET0 [0]=EX0
//  ip_reg         in   5       IP: 1 = high priority; bit order as IE[4:0]
//  instr_boundary in   1       pulse: current instruction finished (control unit returning to s_start)
//  reti_exec      in   1       pulse: RETI executed
//  irq_ack        in   1       pulse: stack push + jump to vector done
//  irq_req        out  1       vectoring request to control unit
//  vector_addr    out  ADDR_W  VEC_BASE + idx*VEC_STRIDE of granted source
//  flags          out  5       pending flags {RI/TI, TF1, IE1, TF0, IE0} for SFR readback
//  in_service     out  2       {high, low} in-service level bits
// BEHAVIOUR
//  Reset: irq_req=0, vector_addr=0, flags=0, in_service=0, FSM=S_IDLE, pin synchronisers=1.
//  INTx: 2-flop sync. Edge mode: sync falling edge sets IEx, cleared at irq_ack of that source; set wins on same-cycle set/clear.
//   Level mode: IEx = ~synced pin each cycle, no latch. TFx set by tf_set, cleared at its irq_ack. flags[4] = serial_irq.
//  Eligible source: flag=1 AND IE enable bit AND EA AND level > current: none in service -> any;
//   low in service -> high only; high in service -> none.
//  Arbitration: high group before low; within a group IE0>TF0>IE1>TF1>RI/TI (index 0 wins).
//  FSM: S_IDLE -> S_REQ on instr_boundary with >=1 eligible source; index latched, irq_req=1, vector_addr valid from next cycle.
//   S_REQ: req and vector held stable regardless of flag/IE changes until irq_ack.
//   S_REQ + irq_ack -> S_IDLE: set in_service bit of granted level, clear flag (edge IEx/TFx only), irq_req=0 same edge.
//  Latency: eligible before instr_boundary -> irq_req high at clock after the boundary pulse (1 cycle).
//  RETI: clears highest set in_service bit (high if set, else low); no-op if none.
//   The instruction boundary immediately following reti_exec is skipped (one instruction always runs after RETI).
//  reti_exec and irq_ack in same cycle: RETI clear applied first, then ack set.
//  instr_boundary while in S_REQ ignored. irq_ack in S_IDLE ignored (no state change).
//  reset_n low mid-request: everything returns to reset values immediately; latched edge flags lost.
// STRUCTURE
//  Shared include define_interrupts.v: source indices (SRC_IE0..SRC_SER), IE/IP bit positions,
//   VEC defaults, FSM state encodings S_IDLE/S_REQ.
//  Sub-module int_edge_detect (sync + edge/level flag latch + clear), instanced once per INTx.
//  Arbiter, FSM and in-service tracker live in this module.
// TESTING
//  1 EA=1,EX0=1, IT0=1, falling edge INT0, boundary -> irq_req=1, vector 16'h0003; ack -> IE0 cleared, in_service=2'b01.
//  2 TF0 and IE1 pending, IP[2]=1 (IE1 high) -> vector 16'h0013 granted first; after ack + RETI, next boundary -> 16'h000B.
//  3 Low ISR active (in_service=01), TF1 low pending -> no req; set IP[3]=1 -> req vector 16'h001B, in_service=11.
//  4 RETI with in_service=11 -> 01; boundary right after RETI ignored even with eligible source, second boundary grants.
//  5 Level mode INT1 held low, EX1=1: ack does not clear; pin released -> flags[2]=0 within 3 cycles, no further req.
//  6 reset_n asserted while irq_req=1 -> irq_req=0, flags=0, in_service=0 asynchronously; EA=0 blocks all requests.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the five-source, two-level interrupt controller:
// source indices, IE bit positions, default vectors and FSM encoding.
package interrupt_controller_pkg;

    localparam int NUM_SRC = 5;

    localparam int SRC_IE0 = 0;
    localparam int SRC_TF0 = 1;
    localparam int SRC_IE1 = 2;
    localparam int SRC_TF1 = 3;
    localparam int SRC_SER = 4;

    localparam int IE_EA = 7;

    localparam logic [15:0] VEC_BASE_DEF   = 16'h0003;
    localparam logic [15:0] VEC_STRIDE_DEF = 16'h0008;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

    typedef logic [2:0] src_idx_t;

    // Lowest set index wins, matching the fixed polling order.
    function automatic src_idx_t first_set(input logic [NUM_SRC-1:0] v);
        first_set = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                first_set = src_idx_t'(i);
            end
        end
    endfunction

endpackage

// File: rtl/interrupt_controller_int_edge_detect.sv
// INTx front end: two-flop synchroniser on the active-low pin, then either a
// falling-edge latched flag or a level-following flag depending on edge_mode.
module interrupt_controller_int_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic pin_n,
    input  logic edge_mode,
    input  logic clr,
    output logic flag
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic       flag_q, flag_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
            flag_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            flag_q <= flag_d;
        end
    end

    // A new falling edge wins over a clear arriving in the same cycle.
    always_comb begin
        sync_d = {sync_q[0], pin_n};
        prev_d = sync_q[1];
        if (edge_mode) begin
            flag_d = (prev_q & ~sync_q[1]) | (flag_q & ~clr);
        end else begin
            flag_d = ~sync_q[1];
        end
    end

    assign flag = flag_q;

endmodule

// File: rtl/interrupt_controller.sv
// 8051-style interrupt controller: latches requests, arbitrates by IP level then
// polling order, presents a held vector to the control unit and tracks nesting.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(VEC_BASE_DEF),
    parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(VEC_STRIDE_DEF)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        ext_int_n,
    input  logic [1:0]        it_mode,
    input  logic [1:0]        tf_set,
    input  logic              serial_irq,
    input  logic [7:0]        ie_reg,
    input  logic [4:0]        ip_reg,
    input  logic              instr_boundary,
    input  logic              reti_exec,
    input  logic              irq_ack,
    output logic              irq_req,
    output logic [ADDR_W-1:0] vector_addr,
    output logic [4:0]        flags,
    output logic [1:0]        in_service
);

    logic [1:0]         ext_flag, ext_clr, tf_clr, tf_d, tf_q;
    logic [NUM_SRC-1:0] src_flags, enabled, hi_cand, lo_cand;
    state_e             state_q, state_d;
    src_idx_t           grant_idx_q, grant_idx_d, arb_idx;
    logic               grant_level_q, grant_level_d, arb_level, any_elig;
    logic               grant_fire, ack_fire, skip_q, skip_d;
    logic [1:0]         in_service_q, in_service_d;
    logic [ADDR_W-1:0]  vector_q, vector_d;
    logic               unused_ie_bits;

    assign unused_ie_bits = ^ie_reg[6:5];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            localparam int EXT_SRC = (gi == 0) ? SRC_IE0 : SRC_IE1;
            localparam int TF_SRC  = (gi == 0) ? SRC_TF0 : SRC_TF1;

            assign ext_clr[gi] = ack_fire && (grant_idx_q == src_idx_t'(EXT_SRC));
            assign tf_clr[gi]  = ack_fire && (grant_idx_q == src_idx_t'(TF_SRC));
            assign tf_d[gi]    = tf_set[gi] | (tf_q[gi] & ~tf_clr[gi]);

            assign src_flags[EXT_SRC] = ext_flag[gi];
            assign src_flags[TF_SRC]  = tf_q[gi];

            interrupt_controller_int_edge_detect u_ext (
                .clock     (clock),
                .reset_n   (reset_n),
                .pin_n     (ext_int_n[gi]),
                .edge_mode (it_mode[gi]),
                .clr       (ext_clr[gi]),
                .flag      (ext_flag[gi])
            );
        end
    endgenerate

    assign src_flags[SRC_SER] = serial_irq;

    // A level may only preempt a strictly lower in-service level.
    assign enabled = src_flags & ie_reg[NUM_SRC-1:0] & {NUM_SRC{ie_reg[IE_EA]}};
    assign hi_cand = enabled & ip_reg;
    assign lo_cand = enabled & ~ip_reg;

    always_comb begin
        any_elig  = 1'b0;
        arb_idx   = '0;
        arb_level = 1'b0;
        if (!in_service_q[1] && (|hi_cand)) begin
            any_elig  = 1'b1;
            arb_idx   = first_set(hi_cand);
            arb_level = 1'b1;
        end else if (!(|in_service_q) && (|lo_cand)) begin
            any_elig  = 1'b1;
            arb_idx   = first_set(lo_cand);
        end
    end

    assign grant_fire = (state_q == S_IDLE) && instr_boundary && !skip_q && any_elig;
    assign ack_fire   = (state_q == S_REQ) && irq_ack;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_fire) state_d = S_REQ;
            S_REQ:   if (irq_ack)    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        irq_req = (state_q == S_REQ);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tf_q          <= 2'b00;
            grant_idx_q   <= '0;
            grant_level_q <= 1'b0;
            skip_q        <= 1'b0;
            in_service_q  <= 2'b00;
            vector_q      <= '0;
        end else begin
            tf_q          <= tf_d;
            grant_idx_q   <= grant_idx_d;
            grant_level_q <= grant_level_d;
            skip_q        <= skip_d;
            in_service_q  <= in_service_d;
            vector_q      <= vector_d;
        end
    end

    // RETI release is applied before the ack sets the newly granted level.
    always_comb begin
        grant_idx_d   = grant_fire ? arb_idx : grant_idx_q;
        grant_level_d = grant_fire ? arb_level : grant_level_q;
        vector_d      = grant_fire ? (VEC_BASE + VEC_STRIDE * ADDR_W'(arb_idx)) : vector_q;
        skip_d        = reti_exec ? 1'b1 : (instr_boundary ? 1'b0 : skip_q);
        in_service_d  = in_service_q;
        if (reti_exec) begin
            if (in_service_q[1]) begin
                in_service_d[1] = 1'b0;
            end else begin
                in_service_d[0] = 1'b0;
            end
        end
        if (ack_fire) begin
            in_service_d[grant_level_q] = 1'b1;
        end
    end

    assign vector_addr = vector_q;
    assign flags       = src_flags;
    assign in_service  = in_service_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized bench for interrupt_controller: a transaction-level model predicts
// each grant, a monitor pops the expectation whenever irq_req rises.
module tb_interrupt_controller;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  ext_int_n = 2'b11;
    logic [1:0]  it_mode = 2'b11;
    logic [1:0]  tf_set = 2'b00;
    logic        serial_irq = 1'b0;
    logic [7:0]  ie_reg = 8'h00;
    logic [4:0]  ip_reg = 5'h00;
    logic        instr_boundary = 1'b0;
    logic        reti_exec = 1'b0;
    logic        irq_ack = 1'b0;
    logic        irq_req;
    logic [15:0] vector_addr;
    logic [4:0]  flags;
    logic [1:0]  in_service;

    always #5 clock = ~clock;

    interrupt_controller #(
        .ADDR_W     (16),
        .VEC_BASE   (16'h0003),
        .VEC_STRIDE (16'h0008)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ext_int_n      (ext_int_n),
        .it_mode        (it_mode),
        .tf_set         (tf_set),
        .serial_irq     (serial_irq),
        .ie_reg         (ie_reg),
        .ip_reg         (ip_reg),
        .instr_boundary (instr_boundary),
        .reti_exec      (reti_exec),
        .irq_ack        (irq_ack),
        .irq_req        (irq_req),
        .vector_addr    (vector_addr),
        .flags          (flags),
        .in_service     (in_service)
    );

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int     idx;
        longint cyc;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state
    logic [4:0] m_flags = 5'b0;
    logic       m_is_hi = 1'b0;
    logic       m_is_lo = 1'b0;
    logic       m_skip = 1'b0;
    logic       m_level = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    // Pick by priority level first, then lowest source index.
    function automatic int model_pick(input logic [7:0] ie, input logic [4:0] ip);
        int cur;
        int best;
        int best_lvl;
        int lvl;
        cur = m_is_hi ? 2 : (m_is_lo ? 1 : 0);
        best = -1;
        best_lvl = 0;
        if (!ie[7]) return -1;
        for (int i = 0; i < 5; i++) begin
            if (m_flags[i] && ie[i]) begin
                lvl = ip[i] ? 2 : 1;
                if (lvl > cur && lvl > best_lvl) begin
                    best = i;
                    best_lvl = lvl;
                end
            end
        end
        return best;
    endfunction

    task automatic boundary(output int g);
        exp_t e;
        instr_boundary = 1'b1;
        if (m_skip) begin
            g = -1;
            m_skip = 1'b0;
        end else begin
            g = model_pick(ie_reg, ip_reg);
            if (g >= 0) begin
                e.idx = g;
                e.cyc = cyc;
                exp_q.push_back(e);
                m_level = ip_reg[g];
            end
        end
        tick();
        instr_boundary = 1'b0;
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
        check("grant_seen", 32'(exp_q.size() == 0), 32'd1);
        exp_q.delete();
    endtask

    task automatic ack(input int g, input bit clr_flag);
        irq_ack = 1'b1;
        if (m_level) m_is_hi = 1'b1;
        else m_is_lo = 1'b1;
        if (clr_flag && g < 4) m_flags[g] = 1'b0;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic reti();
        reti_exec = 1'b1;
        if (m_is_hi) m_is_hi = 1'b0;
        else m_is_lo = 1'b0;
        m_skip = 1'b1;
        tick();
        reti_exec = 1'b0;
    endtask

    task automatic check_no_req(input string name);
        tick(3);
        check(name, 32'(irq_req), 32'd0);
    endtask

    // Monitor: every rising irq_req must match the oldest expected grant.
    initial begin
        logic        prev;
        logic [15:0] held;
        exp_t        e;
        prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clock);
            if (irq_req && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: irq_req=1 vector=%h, expected no request", vector_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("req_vector", 32'(vector_addr), 32'(3 + 8 * e.idx));
                    check("req_latency", 32'(cyc - e.cyc), 32'd1);
                    $display("grant src=%0d vector=%h in_service=%b", e.idx, vector_addr, in_service);
                end
                held = vector_addr;
            end else if (irq_req && prev) begin
                check("vector_hold", 32'(vector_addr), 32'(held));
            end
            prev = irq_req;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         g;
        logic [7:0] ev;

        tick(2);
        check("rst_irq_req", 32'(irq_req), 32'd0);
        check("rst_vector", 32'(vector_addr), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_in_service", 32'(in_service), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Edge-triggered INT0 grant and clear on ack
        ie_reg = 8'h81;
        ext_int_n[0] = 1'b0;
        m_flags[0] = 1'b1;
        tick(2);
        ext_int_n[0] = 1'b1;
        tick(3);
        check("ie0_flag", 32'(flags), 32'(m_flags));
        boundary(g);
        wait_grant();
        ack(g, 1'b1);
        tick();
        check("ie0_cleared", 32'(flags), 32'(m_flags));
        check("ie0_in_service", 32'(in_service), 32'({m_is_hi, m_is_lo}));

        for (int it = 0; it < 150; it++) begin
            ie_reg = {($urandom_range(0, 7) != 0), 2'b00, 5'($urandom)};
            ip_reg = 5'($urandom);
            ev = 8'($urandom);
            if (ev[0]) ext_int_n[0] = 1'b0;
            if (ev[1]) ext_int_n[1] = 1'b0;
            tf_set = ev[3:2];
            serial_irq = (ev[7:5] == 3'b000);
            m_flags[0] = m_flags[0] | ev[0];
            m_flags[2] = m_flags[2] | ev[1];
            m_flags[1] = m_flags[1] | ev[2];
            m_flags[3] = m_flags[3] | ev[3];
            m_flags[4] = serial_irq;
            tick();
            tf_set = 2'b00;
            tick();
            ext_int_n = 2'b11;
            tick(4);
            check("flags", 32'(flags), 32'(m_flags));
            if ((m_is_hi || m_is_lo) && $urandom_range(0, 1) == 1) reti();
            if ($urandom_range(0, 1) == 1) tick($urandom_range(0, 3));
            boundary(g);
            if (g >= 0) begin
                wait_grant();
                if ($urandom_range(0, 1) == 1) begin
                    ie_reg = 8'($urandom);
                    instr_boundary = 1'b1;
                    tick();
                    instr_boundary = 1'b0;
                end
                tick();
                ack(g, 1'b1);
                tick();
                check("in_service", 32'(in_service), 32'({m_is_hi, m_is_lo}));
                check("flags_after_ack", 32'(flags), 32'(m_flags));
            end else begin
                check_no_req("no_req");
            end
        end

        // Async reset while a request is outstanding over a low-level ISR
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_flags = 5'b0; m_is_hi = 1'b0; m_is_lo = 1'b0; m_skip = 1'b0;
        serial_irq = 1'b0;
        ie_reg = 8'h8A;
        ip_reg = 5'b01000;
        tf_set = 2'b01; m_flags[1] = 1'b1;
        tick();
        tf_set = 2'b00;
        tick();
        boundary(g);
        wait_grant();
        ack(g, 1'b1);
        tf_set = 2'b11; m_flags[1] = 1'b1; m_flags[3] = 1'b1;
        tick();
        tf_set = 2'b00;
        tick();
        check("low_isr", 32'(in_service), 32'b01);
        boundary(g);
        wait_grant();
        check("req_before_rst", 32'(irq_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_irq_req", 32'(irq_req), 32'd0);
        check("async_flags", 32'(flags), 32'd0);
        check("async_in_service", 32'(in_service), 32'd0);
        check("async_vector", 32'(vector_addr), 32'd0);
        tick(2);
        reset_n = 1'b1;
        m_flags = 5'b0; m_is_hi = 1'b0; m_is_lo = 1'b0; m_skip = 1'b0;
        tick();

        // EA=0 blocks everything
        ie_reg = 8'h0A;
        tf_set = 2'b11; m_flags[1] = 1'b1; m_flags[3] = 1'b1;
        tick();
        tf_set = 2'b00;
        tick();
        boundary(g);
        check_no_req("ea_off_no_req");

        // Level-mode INT1: ack does not clear, release drops flag within 3 cycles
        ie_reg = 8'h84;
        ip_reg = 5'b00000;
        it_mode = 2'b01;
        ext_int_n[1] = 1'b0;
        m_flags[2] = 1'b1;
        tick(4);
        check("level_flag", 32'(flags), 32'(m_flags));
        boundary(g);
        wait_grant();
        ack(g, 1'b0);
        tick();
        check("level_kept", 32'(flags), 32'(m_flags));
        check("level_in_service", 32'(in_service), 32'b01);
        ext_int_n[1] = 1'b1;
        m_flags[2] = 1'b0;
        tick(3);
        check("level_released", 32'(flags), 32'(m_flags));
        reti();
        boundary(g);
        boundary(g);
        check_no_req("level_no_req");

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
